// File: rtl/axi4_lite_pkg.sv
// ============================================================================
// Module : axi4_lite_pkg
// Brief  : Shared response codes, FSM state types and address decode helper
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [0:0] {
    W_IDLE = 1'b0,
    W_RESP = 1'b1
  } wr_state_t;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_t;

  // Word index from a byte address; the two byte-offset bits are discarded.
  function automatic logic [7:0] addr_to_index(input logic [31:0] addr,
                                               input int unsigned idx_w);
    logic [31:0] mask;
    mask = (32'd1 << idx_w) - 32'd1;
    return 8'((addr >> 2) & mask);
  endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_lite_reg_bank.sv
// ============================================================================
// Module : axi4_lite_reg_bank
// Brief  : Register array with byte-enable writes and per-register write pulses
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_lite_reg_bank
  import axi4_lite_pkg::*;
#(
  parameter int unsigned             NUM_REGS    = 8,
  parameter int unsigned             DATA_WIDTH  = 32,
  parameter int unsigned             IDX_W       = $clog2(NUM_REGS),
  parameter logic [DATA_WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we_i,
  input  logic [IDX_W-1:0]               idx_i,
  input  logic [DATA_WIDTH-1:0]          wdata_i,
  input  logic [DATA_WIDTH/8-1:0]        wstrb_i,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o,
  output logic [NUM_REGS-1:0]            wr_pulse_o
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [NUM_REGS];
  logic [NUM_REGS-1:0]   wr_pulse_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_q[i] <= RESET_VALUE;
      end
      wr_pulse_q <= '0;
    end else begin
      wr_pulse_q <= '0;
      if (we_i) begin
        // The pulse fires even when no strobe bit is set.
        wr_pulse_q[idx_i] <= 1'b1;
        for (int b = 0; b < STRB_W; b++) begin
          if (wstrb_i[b]) begin
            mem_q[idx_i][8*b +: 8] <= wdata_i[8*b +: 8];
          end
        end
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign regs_o[DATA_WIDTH*i +: DATA_WIDTH] = mem_q[i];
  end

  assign wr_pulse_o = wr_pulse_q;

endmodule

`default_nettype wire

// File: rtl/axi4_lite_slave_regs.sv
// ============================================================================
// Module : axi4_lite_slave_regs
// Brief  : AXI4-lite register-bank responder; AXI4_LITE_WSTRB_EN adds wstrb
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module axi4_lite_slave_regs
  import axi4_lite_pkg::*;
#(
  parameter int unsigned                 ADDRESS_WIDTH  = 32,
  parameter int unsigned                 REG_DATA_WIDTH = 32,
  parameter int unsigned                 NUM_REGS       = 8,
  parameter logic [REG_DATA_WIDTH-1:0]   RESET_VALUE    = 32'h0
) (
  input  logic                               axi4_lite_aclk,
  input  logic                               axi4_lite_areset,
  input  logic [ADDRESS_WIDTH-1:0]           axi4_lite_awaddr,
  input  logic                               axi4_lite_awvalid,
  output logic                               axi4_lite_awready,
  input  logic [REG_DATA_WIDTH-1:0]          axi4_lite_wdata,
`ifdef AXI4_LITE_WSTRB_EN
  input  logic [REG_DATA_WIDTH/8-1:0]        axi4_lite_wstrb,
`endif
  input  logic                               axi4_lite_wvalid,
  output logic                               axi4_lite_wready,
  output logic [1:0]                         axi4_lite_bresp,
  output logic                               axi4_lite_bvalid,
  input  logic                               axi4_lite_bready,
  input  logic [ADDRESS_WIDTH-1:0]           axi4_lite_araddr,
  input  logic                               axi4_lite_arvalid,
  output logic                               axi4_lite_arready,
  output logic [REG_DATA_WIDTH-1:0]          axi4_lite_rdata,
  output logic [1:0]                         axi4_lite_rresp,
  output logic                               axi4_lite_rvalid,
  input  logic                               axi4_lite_rready,
  output logic [NUM_REGS*REG_DATA_WIDTH-1:0] regs_q,
  output logic [NUM_REGS-1:0]                wr_pulse
);

  localparam int unsigned IDX_W  = $clog2(NUM_REGS);
  localparam int unsigned STRB_W = REG_DATA_WIDTH / 8;

  // ---------------- write channel ----------------
  wr_state_t                 wr_state_q, wr_state_d;
  logic                      awready_q, awready_d;
  logic                      wready_q, wready_d;
  logic                      aw_done_q, aw_done_d;
  logic                      w_done_q, w_done_d;
  logic [ADDRESS_WIDTH-1:0]  awaddr_q, awaddr_d;
  logic [REG_DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]         wstrb_q, wstrb_d;
  logic                      bvalid_q, bvalid_d;
  logic [1:0]                bresp_q, bresp_d;

  logic                      w_aw_hs, w_w_hs, w_commit, w_aw_in_range;
  logic [ADDRESS_WIDTH-1:0]  w_waddr;
  logic [REG_DATA_WIDTH-1:0] w_wdata;
  logic [STRB_W-1:0]         w_wstrb_in, w_wstrb;
  logic [IDX_W-1:0]          w_aw_idx;

`ifdef AXI4_LITE_WSTRB_EN
  assign w_wstrb_in = axi4_lite_wstrb;
`else
  assign w_wstrb_in = '1;
`endif

  assign w_aw_hs = axi4_lite_awvalid && awready_q;
  assign w_w_hs  = axi4_lite_wvalid && wready_q;

  // Commit uses the live bus value when the handshake lands on this edge.
  assign w_waddr       = w_aw_hs ? axi4_lite_awaddr : awaddr_q;
  assign w_wdata       = w_w_hs ? axi4_lite_wdata : wdata_q;
  assign w_wstrb       = w_w_hs ? w_wstrb_in : wstrb_q;
  assign w_aw_idx      = IDX_W'(addr_to_index(32'(w_waddr), IDX_W));
  assign w_aw_in_range = (w_waddr >> (IDX_W + 2)) == '0;

  always_comb begin
    wr_state_d = wr_state_q;
    awready_d  = awready_q;
    wready_d   = wready_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bvalid_d   = bvalid_q;
    bresp_d    = bresp_q;
    w_commit   = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        if (w_aw_hs) begin
          awaddr_d  = axi4_lite_awaddr;
          aw_done_d = 1'b1;
        end
        if (w_w_hs) begin
          wdata_d  = axi4_lite_wdata;
          wstrb_d  = w_wstrb_in;
          w_done_d = 1'b1;
        end
        awready_d = !aw_done_d;
        wready_d  = !w_done_d;
        if (aw_done_d && w_done_d) begin
          w_commit   = 1'b1;
          aw_done_d  = 1'b0;
          w_done_d   = 1'b0;
          awready_d  = 1'b0;
          wready_d   = 1'b0;
          bvalid_d   = 1'b1;
          bresp_d    = w_aw_in_range ? RESP_OKAY : RESP_SLVERR;
          wr_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (axi4_lite_bready && bvalid_q) begin
          bvalid_d   = 1'b0;
          awready_d  = 1'b1;
          wready_d   = 1'b1;
          wr_state_d = W_IDLE;
        end
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  always_ff @(posedge axi4_lite_aclk) begin
    if (axi4_lite_areset) begin
      wr_state_q <= W_IDLE;
      awready_q  <= 1'b0;
      wready_q   <= 1'b0;
      aw_done_q  <= 1'b0;
      w_done_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bvalid_q   <= 1'b0;
      bresp_q    <= 2'b00;
    end else begin
      wr_state_q <= wr_state_d;
      awready_q  <= awready_d;
      wready_q   <= wready_d;
      aw_done_q  <= aw_done_d;
      w_done_q   <= w_done_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bvalid_q   <= bvalid_d;
      bresp_q    <= bresp_d;
    end
  end

  // ---------------- read channel ----------------
  rd_state_t                 rd_state_q, rd_state_d;
  logic                      arready_q, arready_d;
  logic                      rvalid_q, rvalid_d;
  logic [REG_DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]                rresp_q, rresp_d;

  logic                      w_ar_hs, w_ar_in_range;
  logic [IDX_W-1:0]          w_ar_idx;
  logic [REG_DATA_WIDTH-1:0] w_rd_word;

  assign w_ar_hs       = axi4_lite_arvalid && arready_q;
  assign w_ar_idx      = IDX_W'(addr_to_index(32'(axi4_lite_araddr), IDX_W));
  assign w_ar_in_range = (axi4_lite_araddr >> (IDX_W + 2)) == '0;
  // Bank contents before this edge, so a same-edge write is not visible.
  assign w_rd_word     = regs_q[w_ar_idx*REG_DATA_WIDTH +: REG_DATA_WIDTH];

  always_comb begin
    rd_state_d = rd_state_q;
    arready_d  = arready_q;
    rvalid_d   = rvalid_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    case (rd_state_q)
      R_IDLE: begin
        if (w_ar_hs) begin
          arready_d  = 1'b0;
          rvalid_d   = 1'b1;
          rdata_d    = w_ar_in_range ? w_rd_word : '0;
          rresp_d    = w_ar_in_range ? RESP_OKAY : RESP_SLVERR;
          rd_state_d = R_DATA;
        end else begin
          arready_d = 1'b1;
        end
      end
      R_DATA: begin
        if (axi4_lite_rready && rvalid_q) begin
          rvalid_d   = 1'b0;
          arready_d  = 1'b1;
          rd_state_d = R_IDLE;
        end
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axi4_lite_aclk) begin
    if (axi4_lite_areset) begin
      rd_state_q <= R_IDLE;
      arready_q  <= 1'b0;
      rvalid_q   <= 1'b0;
      rdata_q    <= '0;
      rresp_q    <= 2'b00;
    end else begin
      rd_state_q <= rd_state_d;
      arready_q  <= arready_d;
      rvalid_q   <= rvalid_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  axi4_lite_reg_bank #(
    .NUM_REGS    (NUM_REGS),
    .DATA_WIDTH  (REG_DATA_WIDTH),
    .IDX_W       (IDX_W),
    .RESET_VALUE (RESET_VALUE)
  ) u_reg_bank (
    .clk_i      (axi4_lite_aclk),
    .rst_i      (axi4_lite_areset),
    .we_i       (w_commit && w_aw_in_range),
    .idx_i      (w_aw_idx),
    .wdata_i    (w_wdata),
    .wstrb_i    (w_wstrb),
    .regs_o     (regs_q),
    .wr_pulse_o (wr_pulse)
  );

  assign axi4_lite_awready = awready_q;
  assign axi4_lite_wready  = wready_q;
  assign axi4_lite_bvalid  = bvalid_q;
  assign axi4_lite_bresp   = bresp_q;
  assign axi4_lite_arready = arready_q;
  assign axi4_lite_rvalid  = rvalid_q;
  assign axi4_lite_rdata   = rdata_q;
  assign axi4_lite_rresp   = rresp_q;

endmodule

`default_nettype wire

// File: doc/axi4_lite_slave_regs.md
Name: axi4_lite_slave_regs

Overview:
AXI4-lite responder, the slave end of the team's axi4_lite_interface. It holds a bank of NUM_REGS 32-bit read/write registers. It decodes master writes and reads, and returns OKAY or SLVERR responses. The bank is exposed to user logic as a flat vector plus per-register write pulses, and sits between the bus fabric and peripheral control logic.

Parameters:
ADDRESS_WIDTH, 32, width of awaddr/araddr
REG_DATA_WIDTH, 32, register and data width (only 32 supported)
NUM_REGS, 8, number of registers (power of 2, 2..256)
RESET_VALUE, 32'h0, reset value of every register

Ports:
axi4_lite_aclk  in  1  system clock
axi4_lite_areset  in  1  synchronous active-high reset
axi4_lite_awaddr  in  ADDRESS_WIDTH  write address
axi4_lite_awvalid  in  1  write address valid
axi4_lite_awready  out  1  write address ready
axi4_lite_wdata  in  REG_DATA_WIDTH  write data
axi4_lite_wvalid  in  1  write data valid
axi4_lite_wready  out  1  write data ready
axi4_lite_bresp  out  2  write response
axi4_lite_bvalid  out  1  write response valid
axi4_lite_bready  in  1  write response ready
axi4_lite_araddr  in  ADDRESS_WIDTH  read address
axi4_lite_arvalid  in  1  read address valid
axi4_lite_arready  out  1  read address ready
axi4_lite_rdata  out  REG_DATA_WIDTH  read data
axi4_lite_rresp  out  2  read response
axi4_lite_rvalid  out  1  read data valid
axi4_lite_rready  in  1  read data ready
regs_q  out  NUM_REGS*32  register contents; reg i at [32*i+:32]
wr_pulse  out  NUM_REGS  one-cycle strobe, asserted the cycle after reg i is written

Behaviour:
- Reset (axi4_lite_areset=1, sampled on clock edge):
  - all registers go to RESET_VALUE.
  - awready, wready, arready, bvalid, rvalid and wr_pulse go to 0; bresp, rresp and rdata go to 0.
  - both FSMs go to IDLE.
  - reset mid-transaction abandons the transaction with no response.
- Readies are registered; they read 1 in the first cycle after reset deasserts.
- Write FSM, states W_IDLE, W_RESP:
  - W_IDLE: awready=1 until an AW handshake, then 0 and the address is latched. wready=1 until a W handshake, then 0 and the data is latched.
  - AW and W may handshake in the same cycle or in either order, any gap apart.
  - On the edge where both are captured, the write is committed and the FSM moves to W_RESP; bvalid=1 from the next cycle.
  - W_RESP: bvalid and bresp held stable until bready. On the handshake, bvalid=0, awready=wready=1, return to W_IDLE.
  - Minimum write cycle: 3 clocks (handshake, response, idle).
- Read FSM, states R_IDLE, R_DATA:
  - R_IDLE: arready=1. On an AR handshake, arready=0, rdata and rresp are registered from the current register values, and the FSM moves to R_DATA; rvalid=1 the next cycle.
  - R_DATA: rvalid, rdata and rresp held stable until rready. On the handshake, rvalid=0, arready=1, return to R_IDLE.
- Address decode:
  - index = addr[2 +: log2(NUM_REGS)]; addr[1:0] ignored.
  - addr >= NUM_REGS*4 is out of range: write dropped with bresp=2'b10 (SLVERR); read returns rdata=0 with rresp=2'b10. Otherwise the response is 2'b00 (OKAY).
- Read and write FSMs are fully independent and may run concurrently.
- Read and write to the same register on the same edge: the read returns the pre-write value.
- wr_pulse[i] is asserted one cycle after each committed in-range write, including repeated writes of the same value.

Optional Feature:
- Macro: AXI4_LITE_WSTRB_EN.
- Defined: adds input port axi4_lite_wstrb (REG_DATA_WIDTH/8 bits), latched with wdata. Only bytes whose strobe bit is 1 are updated. wstrb=0 still gives an OKAY response and asserts wr_pulse.
- Undefined: no wstrb port; every write updates all 4 bytes.

Decomposition:
- Package axi4_lite_pkg holds:
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10;
  - enums wr_state_t {W_IDLE,W_RESP} and rd_state_t {R_IDLE,R_DATA};
  - function addr_to_index.
- A flat port variant may be wrapped to the axi4_lite_interface slave modport by the integrator.
- Sub-module axi4_lite_reg_bank holds the register array, byte-enable write and wr_pulse generation. The top level keeps both FSMs and address decode.

Test Plan:
- After reset: AW+W in the same cycle, addr 0x04, data 0xDEADBEEF, bready=1 -> bvalid 1 cycle later with bresp=00; regs_q[63:32]=0xDEADBEEF; wr_pulse=8'h02 for one cycle.
- W arrives 3 cycles before AW, addr 0x1C, data 0x12345678 -> no bvalid until AW; then OKAY; a read of 0x1C returns 0x12345678 with rresp=00.
- Write to 0x20 and read from 0x40 -> bresp=10 with no register changed; rdata=0 with rresp=10.
- bready and rready held 0 for 5 cycles -> bvalid, rvalid, rdata and resp stay stable; awready and arready stay 0; no second transaction is accepted.
- Concurrent write of 0xA5A5A5A5 and read of 0x08 on the same edge, reg2 previously 0x11 -> read returns 0x11, and a subsequent read returns 0xA5A5A5A5.
- Reset asserted while in W_RESP -> bvalid=0 the next cycle, all regs=RESET_VALUE, readies=1 in the first cycle after release.
- With AXI4_LITE_WSTRB_EN: reg 0 = 0xFFFFFFFF, write 0x00000000 with wstrb=4'b0101 -> regs_q[31:0]=0xFF00FF00.
